// File: rtl/stage_wr_writeback_if.sv
// MEM -> WR handshake bundle: one instruction per valid/ready transfer.
interface stage_wr_writeback_if #(
  parameter int DATA_W = 32
);
  logic              MEMin_Valid;
  logic              MEMin_Ready;
  logic              MEMin_RegWr;
  logic              MEMin_MemtoReg;
  logic [4:0]        MEMin_Rw;
  logic [DATA_W-1:0] MEMin_ALUout;
  logic [DATA_W-1:0] MEMin_Dout;

  // MEM stage side: presents the instruction, observes ready
  modport master (
    output MEMin_Valid, MEMin_RegWr, MEMin_MemtoReg, MEMin_Rw, MEMin_ALUout, MEMin_Dout,
    input  MEMin_Ready
  );

  // WR stage side: consumes the instruction, drives ready
  modport slave (
    input  MEMin_Valid, MEMin_RegWr, MEMin_MemtoReg, MEMin_Rw, MEMin_ALUout, MEMin_Dout,
    output MEMin_Ready
  );
endinterface

// File: rtl/stage_wr_writeback.sv
// Write-back stage: MEM/WR pipeline register, write-data mux at capture,
// register-file write port, last-write bypass and retired-instruction counter.
module stage_wr_writeback #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  stage_wr_writeback_if.slave mem,
  input  logic                Stall,
  input  logic                Flush,
  output logic                WR_RegWE,
  output logic [4:0]          WR_Rw,
  output logic [DATA_W-1:0]   WR_RegDin,
  output logic                WR_Valid,
  output logic                Byp_Valid,
  output logic [4:0]          Byp_Rw,
  output logic [DATA_W-1:0]   Byp_Data,
  output logic [CNT_W-1:0]    Retired
);

  logic              valid;
  logic              regwr;
  logic [4:0]        rw;
  logic [DATA_W-1:0] data;
  logic              byp_valid;
  logic [4:0]        byp_rw;
  logic [DATA_W-1:0] byp_data;
  logic [CNT_W-1:0]  retired;

  logic commit;
  logic ready;
  logic accept;
  logic reg_we;

  // Handshake and write-enable decode; a $0 destination retires without writing
  always_comb begin
    commit = valid & ~Stall & ~Flush;
    ready  = ~Flush & (~valid | commit);
    accept = mem.MEMin_Valid & ready;
    reg_we = commit & regwr & (rw != 5'd0);
  end

  assign mem.MEMin_Ready = ready;
  assign WR_RegWE        = reg_we;
  assign WR_Rw           = rw;
  assign WR_RegDin       = data;
  assign WR_Valid        = valid;
  assign Byp_Valid       = byp_valid;
  assign Byp_Rw          = byp_rw;
  assign Byp_Data        = byp_data;
  assign Retired         = retired;

  // Pipeline register, bypass capture and retire counter; reset > flush > normal
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid     <= 1'b0;
      regwr     <= 1'b0;
      rw        <= '0;
      data      <= '0;
      byp_valid <= 1'b0;
      byp_rw    <= '0;
      byp_data  <= '0;
      retired   <= '0;
    end else if (Flush) begin
      // Held entry is dropped; ready is low so nothing new enters
      valid <= 1'b0;
    end else begin
      if (commit) begin
        retired <= retired + 1'b1;
        if (reg_we) begin
          byp_valid <= 1'b1;
          byp_rw    <= rw;
          byp_data  <= data;
        end
      end
      if (accept) begin
        valid <= 1'b1;
        regwr <= mem.MEMin_RegWr;
        rw    <= mem.MEMin_Rw;
        // MemtoReg only steers the mux here; it is not kept in the entry
        data  <= mem.MEMin_MemtoReg ? mem.MEMin_Dout : mem.MEMin_ALUout;
      end else if (commit) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
